ex_muldiv_ctrl: RTL and testbench

Sequencer for the RV32M multiply/divide unit. It handles the R-format instructions with funct7 = 7'b0000001 that the plain R-type decode path rejects. It accepts an operand pair from decode, stalls the pipeline while an iterative shift-add multiply or restoring divide runs, then presents the result together with a register write request to writeback. It sits beside the ALU in the execute stage and owns the only multi-cycle arithmetic resource in the core.

---
 rtl/ex_muldiv_ctrl_pkg.sv | 43 ++++
 rtl/ex_muldiv_ctrl_if.sv | 32 +++
 rtl/ex_muldiv_ctrl_step.sv | 41 ++++
 rtl/ex_muldiv_ctrl.sv | 144 ++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg
//   Shared widths, RV32M opcode constants, state type and a small helper
//   used by the multiply/divide sequencer and its interface.
package ex_muldiv_ctrl_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned RDATA_WIDTH = 32;
  localparam int unsigned RADDR_WIDTH = 5;

  localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;

  // Most negative signed operand, used by the signed-overflow fast path.
  localparam logic [RDATA_WIDTH-1:0] MD_INT_MIN = {1'b1, {(RDATA_WIDTH-1){1'b0}}};

  // Encodings match the legacy MD_* defines.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Two's-complement negate when n is set.
  function automatic logic [RDATA_WIDTH-1:0] neg_if(input logic n,
                                                    input logic [RDATA_WIDTH-1:0] v);
    return n ? (~v + {{(RDATA_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if
//   Decode/writeback side of the multiply/divide sequencer.
//   master: decode/pipeline side (drives start, flush, operation, operands, rd)
//   slave : the sequencer (drives stall, busy, ready, result, write request)
interface ex_muldiv_ctrl_if;
  import ex_muldiv_ctrl_pkg::*;

  logic                   start_i;
  logic                   flush_i;
  logic [2:0]             funct3_i;
  logic [RDATA_WIDTH-1:0] op1_i;
  logic [RDATA_WIDTH-1:0] op2_i;
  logic [RADDR_WIDTH-1:0] waddr_i;

  logic                   stall_o;
  logic                   busy_o;
  logic                   ready_o;
  logic [RDATA_WIDTH-1:0] result_o;
  logic                   reg_we_o;
  logic [RADDR_WIDTH-1:0] reg_waddr_o;

  modport master (
    output start_i, flush_i, funct3_i, op1_i, op2_i, waddr_i,
    input  stall_o, busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, op1_i, op2_i, waddr_i,
    output stall_o, busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
  );

endinterface

// File: rtl/ex_muldiv_ctrl_step.sv
// muldiv_step
//   One combinational iteration on the 64-bit working register.
//   i_is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   i_work    : multiply {acc_hi, multiplier}, divide {remainder, quotient}
//   i_operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   o_work    : working register after one step
module muldiv_step
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic                     i_is_div,
  input  logic [2*RDATA_WIDTH-1:0] i_work,
  input  logic [RDATA_WIDTH-1:0]   i_operand,
  output logic [2*RDATA_WIDTH-1:0] o_work
);

  logic [RDATA_WIDTH:0] w_sum;
  logic [RDATA_WIDTH:0] w_diff;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the 65-bit {carry, acc} right.
    w_sum  = {1'b0, i_work[2*RDATA_WIDTH-1:RDATA_WIDTH]} + {1'b0, i_operand};
    // Divide: trial subtraction on the left-shifted remainder. The partial
    // remainder is always below the divisor, so bit RDATA_WIDTH of the
    // difference is exactly the borrow.
    w_diff = i_work[2*RDATA_WIDTH-1:RDATA_WIDTH-1] - {1'b0, i_operand};

    if (i_is_div) begin
      if (!w_diff[RDATA_WIDTH])
        o_work = {w_diff[RDATA_WIDTH-1:0], i_work[RDATA_WIDTH-2:0], 1'b1};
      else
        o_work = {i_work[2*RDATA_WIDTH-2:RDATA_WIDTH-1], i_work[RDATA_WIDTH-2:0], 1'b0};
    end else begin
      if (i_work[0])
        o_work = {w_sum, i_work[RDATA_WIDTH-1:1]};
      else
        o_work = {1'b0, i_work[2*RDATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
//   RV32M multiply/divide sequencer in the execute stage. Accepts an operand
//   pair, stalls the pipeline during a 32-step shift-add multiply or
//   restoring divide, then presents the result with a writeback request.
//   clk, rst : core clock, synchronous active-high reset
//   md       : slave side of ex_muldiv_ctrl_if (start/flush/funct3/operands/rd
//              in; stall/busy/ready/result/reg_we/reg_waddr out)
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ex_muldiv_ctrl_if.slave md
);

  md_state_e                r_state;
  logic [4:0]               r_cnt;
  logic [2:0]               r_f3;
  logic [RADDR_WIDTH-1:0]   r_waddr;
  logic                     r_neg_a;
  logic                     r_neg_b;
  logic [RDATA_WIDTH-1:0]   r_operand;
  logic [2*RDATA_WIDTH-1:0] r_work;
  logic [RDATA_WIDTH-1:0]   r_result;

  logic                     w_sign_a;
  logic                     w_sign_b;
  logic                     w_neg_a;
  logic                     w_neg_b;
  logic [RDATA_WIDTH-1:0]   w_mag_a;
  logic [RDATA_WIDTH-1:0]   w_mag_b;
  logic                     w_is_div;
  logic                     w_div_zero;
  logic                     w_div_ovf;
  logic                     w_accept;
  logic [2*RDATA_WIDTH-1:0] w_step;
  logic [2*RDATA_WIDTH-1:0] w_prod;
  logic [RDATA_WIDTH-1:0]   w_fix_result;
  logic                     w_ready;

  always_comb begin
    w_sign_a   = (md.funct3_i == INST_MULH) || (md.funct3_i == INST_MULHSU) ||
                 (md.funct3_i == INST_DIV)  || (md.funct3_i == INST_REM);
    w_sign_b   = (md.funct3_i == INST_MULH) || (md.funct3_i == INST_DIV) ||
                 (md.funct3_i == INST_REM);
    w_neg_a    = w_sign_a & md.op1_i[RDATA_WIDTH-1];
    w_neg_b    = w_sign_b & md.op2_i[RDATA_WIDTH-1];
    w_mag_a    = neg_if(w_neg_a, md.op1_i);
    w_mag_b    = neg_if(w_neg_b, md.op2_i);
    w_is_div   = md.funct3_i[2];
    w_div_zero = w_is_div && (md.op2_i == '0);
    // Only the signed variants (funct3[0] = 0) can overflow.
    w_div_ovf  = w_is_div && !md.funct3_i[0] &&
                 (md.op1_i == MD_INT_MIN) && (md.op2_i == '1);
    w_accept   = (r_state == MD_IDLE) && md.start_i && !md.flush_i;
  end

  muldiv_step u_step (
    .i_is_div  (r_f3[2]),
    .i_work    (r_work),
    .i_operand (r_operand),
    .o_work    (w_step)
  );

  // Sign fix-up and word select; the flags are only ever set for signed variants.
  always_comb begin
    w_prod = (r_neg_a ^ r_neg_b) ? (~r_work + {{(2*RDATA_WIDTH-1){1'b0}}, 1'b1}) : r_work;
    if (r_f3[2])
      w_fix_result = r_f3[1] ? neg_if(r_neg_a, r_work[2*RDATA_WIDTH-1:RDATA_WIDTH])
                             : neg_if(r_neg_a ^ r_neg_b, r_work[RDATA_WIDTH-1:0]);
    else
      w_fix_result = (r_f3[1:0] == 2'b00) ? w_prod[RDATA_WIDTH-1:0]
                                          : w_prod[2*RDATA_WIDTH-1:RDATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_waddr   <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_operand <= '0;
      r_work    <= '0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_f3      <= md.funct3_i;
            r_waddr   <= md.waddr_i;
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_cnt     <= 5'd31;
            r_operand <= w_is_div ? w_mag_b : w_mag_a;
            r_work    <= {{RDATA_WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            if (w_div_zero) begin
              r_result <= md.funct3_i[1] ? md.op1_i : '1;
              r_state  <= MD_DONE;
            end else if (w_div_ovf) begin
              r_result <= md.funct3_i[1] ? '0 : MD_INT_MIN;
              r_state  <= MD_DONE;
            end else begin
              r_state  <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (md.flush_i) begin
            r_state <= MD_IDLE;
          end else begin
            r_work <= w_step;
            if (r_cnt == 5'd0)
              r_state <= MD_FIX;
            else
              r_cnt <= r_cnt - 5'd1;
          end
        end
        MD_FIX: begin
          if (md.flush_i) begin
            r_state <= MD_IDLE;
          end else begin
            r_result <= w_fix_result;
            r_state  <= MD_DONE;
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready        = (r_state == MD_DONE) && !md.flush_i;
    md.busy_o      = (r_state != MD_IDLE);
    md.stall_o     = w_accept || (r_state == MD_CALC) || (r_state == MD_FIX);
    md.ready_o     = w_ready;
    md.result_o    = w_ready ? r_result : '0;
    md.reg_we_o    = w_ready ? WRITE_ENABLE : WRITE_DISABLE;
    md.reg_waddr_o = w_ready ? r_waddr : ZERO_REG;
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl
//   Directed bench for ex_muldiv_ctrl: an arithmetic reference model with a
//   cycle-count latency model, a per-cycle output compare, and literal
//   expectations on each directed operation.
module tb_ex_muldiv_ctrl;
  import ex_muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_ctrl_if bus();

  ex_muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ready = 0;
  logic checking = 1'b0;

  // Reference model: busy flag, cycles left before the result cycle, result.
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_res  = '0;
  logic [4:0]  m_rd   = '0;

  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    return f3[2] && ((b == 0) ||
                     (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (bus.start_i && !bus.flush_i) begin
        m_busy = 1'b1;
        m_cnt  = is_fast(bus.funct3_i, bus.op1_i, bus.op2_i) ? 0 : 33;
        m_res  = ref_result(bus.funct3_i, bus.op1_i, bus.op2_i);
        m_rd   = bus.waddr_i;
      end
    end else if (bus.flush_i || m_cnt == 0) begin
      m_busy = 1'b0;
    end else begin
      m_cnt = m_cnt - 1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic        e_ready, e_stall;
    logic [40:0] exp_v, got_v;
    if (checking) begin
      e_ready = m_busy && (m_cnt == 0) && !bus.flush_i;
      e_stall = (!m_busy && bus.start_i && !bus.flush_i) || (m_busy && m_cnt > 0);
      exp_v = {m_busy, e_stall, e_ready, e_ready,
               (e_ready ? m_rd : 5'd0), (e_ready ? m_res : 32'd0)};
      got_v = {bus.busy_o, bus.stall_o, bus.ready_o, bus.reg_we_o,
               bus.reg_waddr_o, bus.result_o};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t {busy,stall,ready,we,waddr,result} got=%h exp=%h",
                 $time, got_v, exp_v);
      end
      if (bus.ready_o === 1'b1) n_ready++;
    end
  end

  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic [37:0] got;
    lat = 0;
    got = '0;
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.funct3_i = f3;
    bus.op1_i    = a;
    bus.op2_i    = b;
    bus.waddr_i  = rd;
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        lat = k;
        got = {bus.reg_we_o, bus.reg_waddr_o, bus.result_o};
        break;
      end
    end
    n_tests++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL %s timeout: no ready_o within 60 cycles, required latency %0d",
               name, exp_lat);
    end else if (got !== {1'b1, rd, exp_res} || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s {we,waddr,result}=%h latency=%0d required %h latency=%0d",
               name, got, lat, {1'b1, rd, exp_res}, exp_lat);
    end
  endtask

  task automatic check_lit(input string name, input logic [40:0] got,
                           input logic [40:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp_v);
    end
  endtask

  function automatic logic [40:0] outs();
    return {bus.busy_o, bus.stall_o, bus.ready_o, bus.reg_we_o,
            bus.reg_waddr_o, bus.result_o};
  endfunction

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish within 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = '0;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    bus.waddr_i  = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_lit("reset_outputs", outs(), 41'd0);
    checking = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Multiply variants
    issue("mul_7_x_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34);
    issue("mulh_min_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 32'h4000_0000, 34);
    issue("mulhu_min_min",   3'd3, 32'h8000_0000,  32'h8000_0000, 5'd3, 32'h4000_0000, 34);
    issue("mulhsu_m1_ffff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34);

    // Divide variants
    issue("div_m7_2",        3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5, 32'hFFFF_FFFD, 34);
    issue("rem_m7_2",        3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6, 32'hFFFF_FFFF, 34);
    issue("divu_100_7",      3'd5, 32'd100,        32'd7,         5'd7, 32'd14,        34);
    issue("remu_100_7",      3'd7, 32'd100,        32'd7,         5'd8, 32'd2,         34);

    // Fast paths
    issue("divu_by_zero",    3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1);
    issue("remu_by_zero",    3'd7, 32'd5,          32'd0,         5'd10, 32'd5,         1);
    issue("div_overflow",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    issue("rem_overflow",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1);

    // Flush 10 cycles into CALC
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'd0;
    bus.op1_i = 32'd9; bus.op2_i = 32'd9; bus.waddr_i = 5'd13;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    r0 = n_ready;
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check_lit("flush_busy_drop", {40'd0, bus.busy_o}, 41'd0);
    repeat (40) @(posedge clk);
    check_lit("flush_no_ready", 41'(n_ready - r0), 41'd0);
    issue("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 34);

    // Reset while in FIX
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'd5;
    bus.op1_i = 32'd100; bus.op2_i = 32'd7; bus.waddr_i = 5'd15;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    r0 = n_ready;
    repeat (32) @(posedge clk);
    @(negedge clk);
    check_lit("fix_stall_busy", {39'd0, bus.busy_o, bus.stall_o}, 41'd3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_lit("reset_in_fix", outs(), 41'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    check_lit("reset_no_ready", 41'(n_ready - r0), 41'd0);

    // Start pulses while busy (incl. the DONE cycle) are ignored
    r0 = n_ready;
    bus.funct3_i = 3'd3; bus.op1_i = 32'hFFFF_FFFF; bus.op2_i = 32'hFFFF_FFFF;
    bus.waddr_i = 5'd16;
    for (int k = 0; k <= 60; k++) begin
      @(posedge clk); #1;
      bus.start_i = (k < 5) || (k == 34);
    end
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    check_lit("one_result_per_start", 41'(n_ready - r0), 41'd1);

    // Back-to-back after the ignored-start run
    issue("remu_last", 3'd7, 32'd1000, 32'd33, 5'd17, 32'd10, 34);

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
